// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sp_ram_arbiter                                               |
// | Description : Round-robin two-master arbiter in front of one sp_ram_wrap.  |
// |               Optional stall counters: SP_RAM_ARB_STALL_CNT_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sp_ram_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    input  logic                    bypass_en_i,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic                    ram_bypass_en_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    output logic [31:0]             stall_cnt0_o,
    output logic [31:0]             stall_cnt1_o,
    input  logic                    clr_stats_i
);

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic       r_last_gnt;
    logic [1:0] r_rvalid;
    logic       w_gnt0;
    logic       w_gnt1;

    // Under contention the port that did not win last time is served.
    assign w_gnt0 = p0_req_i & (~p1_req_i | r_last_gnt);
    assign w_gnt1 = p1_req_i & (~p0_req_i | ~r_last_gnt);

    assign p0_gnt_o = w_gnt0;
    assign p1_gnt_o = w_gnt1;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_last_gnt <= 1'b1;
            r_rvalid   <= 2'b00;
        end else begin
            if (w_gnt0 | w_gnt1) begin
                r_last_gnt <= w_gnt1;
            end
            r_rvalid <= {w_gnt1, w_gnt0};
        end
    end

    // Port 0 fields are presented whenever port 1 is not granted.
    assign ram_en_o        = w_gnt0 | w_gnt1;
    assign ram_addr_o      = w_gnt1 ? p1_addr_i  : p0_addr_i;
    assign ram_wdata_o     = w_gnt1 ? p1_wdata_i : p0_wdata_i;
    assign ram_we_o        = w_gnt1 ? p1_we_i    : p0_we_i;
    assign ram_be_o        = w_gnt1 ? p1_be_i    : p0_be_i;
    assign ram_bypass_en_o = bypass_en_i;

    assign p0_rvalid_o = r_rvalid[0];
    assign p1_rvalid_o = r_rvalid[1];
    assign p0_rdata_o  = ram_rdata_i;
    assign p1_rdata_o  = ram_rdata_i;

`ifdef SP_RAM_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt0;
    logic [31:0] r_stall_cnt1;

    always_ff @(posedge clk) begin
        if (rst_i || clr_stats_i) begin
            r_stall_cnt0 <= 32'd0;
            r_stall_cnt1 <= 32'd0;
        end else begin
            if (p0_req_i && !w_gnt0 && r_stall_cnt0 != c_CNT_MAX) begin
                r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
            end
            if (p1_req_i && !w_gnt1 && r_stall_cnt1 != c_CNT_MAX) begin
                r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
            end
        end
    end

    assign stall_cnt0_o = r_stall_cnt0;
    assign stall_cnt1_o = r_stall_cnt1;
`else
    logic        w_unused_clr;
    logic [31:0] w_unused_max;

    assign w_unused_clr = clr_stats_i;
    assign w_unused_max = c_CNT_MAX;
    assign stall_cnt0_o = 32'd0;
    assign stall_cnt1_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sp_ram_arbiter                                            |
// | Description : Randomized self-checking bench with a word-level RAM model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sp_ram_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int WORDS = 8192;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          p0_req_i, p1_req_i, p0_we_i, p1_we_i;
    logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [AW-1:0] p0_addr_i, p1_addr_i, ram_addr_o;
    logic [3:0]    p0_be_i, p1_be_i, ram_be_o;
    logic [DW-1:0] p0_wdata_i, p1_wdata_i, p0_rdata_o, p1_rdata_o;
    logic          bypass_en_i, ram_en_o, ram_we_o, ram_bypass_en_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata;
    logic [31:0]   stall_cnt0_o, stall_cnt1_o;
    logic          clr_stats_i;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i),
        .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i),
        .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .bypass_en_i(bypass_en_i), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_bypass_en_o(ram_bypass_en_o), .ram_rdata_i(ram_rdata),
        .stall_cnt0_o(stall_cnt0_o), .stall_cnt1_o(stall_cnt1_o),
        .clr_stats_i(clr_stats_i)
    );

    // Stand-in for sp_ram_wrap: one-cycle read, byte-enabled write, bypass echoes wdata.
    logic [DW-1:0] ram_mem [WORDS];
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_bypass_en_o) begin
                ram_rdata <= ram_wdata_o;
            end else begin
                ram_rdata <= ram_mem[ram_addr_o[AW-1:2]];
                if (ram_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                    end
                end
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [WORDS];
    int            m_last;
    logic [31:0]   m_cnt0, m_cnt1;
    int            last_g;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: inputs already driven; checks combinational then registered outputs.
    task automatic step();
        int            g;
        logic          rd_chk;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        logic [3:0]    e_be;
        if (p0_req_i && p1_req_i) g = (m_last == 0) ? 1 : 0;
        else if (p0_req_i)        g = 0;
        else if (p1_req_i)        g = 1;
        else                      g = -1;
        last_g = g;
        #1;
        check("gnt0", p0_gnt_o, g == 0);
        check("gnt1", p1_gnt_o, g == 1);
        check("ram_en", ram_en_o, g >= 0);
        check("ram_bypass", ram_bypass_en_o, bypass_en_i);
        e_addr  = (g == 1) ? p1_addr_i  : p0_addr_i;
        e_wdata = (g == 1) ? p1_wdata_i : p0_wdata_i;
        e_we    = (g == 1) ? p1_we_i    : p0_we_i;
        e_be    = (g == 1) ? p1_be_i    : p0_be_i;
        check("ram_addr", ram_addr_o, e_addr);
        check("ram_we", ram_we_o, e_we);
        if (g >= 0) begin
            check("ram_wdata", ram_wdata_o, e_wdata);
            check("ram_be", ram_be_o, e_be);
        end
        rd_chk = 1'b0;
        exp_rd = '0;
        if (g >= 0) begin
            if (bypass_en_i) begin
                rd_chk = 1'b1;
                exp_rd = e_wdata;
            end else if (!e_we) begin
                rd_chk = 1'b1;
                exp_rd = ref_mem[e_addr[AW-1:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) ref_mem[e_addr[AW-1:2]][8*b +: 8] = e_wdata[8*b +: 8];
            end
        end
`ifdef SP_RAM_ARB_STALL_CNT_EN
        if (rst_i || clr_stats_i) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (p0_req_i && g != 0 && m_cnt0 != 32'hFFFF_FFFF) m_cnt0 = m_cnt0 + 1;
            if (p1_req_i && g != 1 && m_cnt1 != 32'hFFFF_FFFF) m_cnt1 = m_cnt1 + 1;
        end
`endif
        if (rst_i) m_last = 1;
        else if (g >= 0) m_last = g;
        @(posedge clk);
        #1;
        check("rvalid0", p0_rvalid_o, !rst_i && g == 0);
        check("rvalid1", p1_rvalid_o, !rst_i && g == 1);
        if (!rst_i && rd_chk) begin
            if (g == 0) check("rdata0", p0_rdata_o, exp_rd);
            else        check("rdata1", p1_rdata_o, exp_rd);
        end
        check("stall_cnt0", stall_cnt0_o, m_cnt0);
        check("stall_cnt1", stall_cnt1_o, m_cnt1);
    endtask

    task automatic set_p0(input logic req, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] d);
        p0_req_i = req; p0_addr_i = a; p0_we_i = we; p0_be_i = be; p0_wdata_i = d;
    endtask

    task automatic set_p1(input logic req, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] d);
        p1_req_i = req; p1_addr_i = a; p1_we_i = we; p1_be_i = be; p1_wdata_i = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_p0(0, '0, 0, '0, '0);
        set_p1(0, '0, 0, '0, '0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        bypass_en_i = 1'b0;
        clr_stats_i = 1'b0;
        #2;
        do_reset();
        check("reset_rvalid0", p0_rvalid_o, 1'b0);
        check("reset_rvalid1", p1_rvalid_o, 1'b0);

        // Write then read back on port 0
        set_p0(1, 15'h10, 1, 4'hF, 32'hDEADBEEF); step();
        set_p0(1, 15'h10, 0, 4'hF, 32'h0);        step();
        check("wr_rd_data", p0_rdata_o, 32'hDEADBEEF);
        set_p0(0, '0, 0, '0, '0); step();

        // Continuous contention from reset: 0,1,0,1,0,1
        do_reset();
        set_p0(1, 15'h10, 0, 4'hF, 0);
        set_p1(1, 15'h20, 0, 4'hF, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("alternate", last_g, i % 2);
        end
        set_p0(0, '0, 0, '0, '0); set_p1(0, '0, 0, '0, '0); step();

        // p1 alone three times, then contention goes to p0
        do_reset();
        set_p1(1, 15'h20, 0, 4'hF, 0);
        repeat (3) step();
        set_p0(1, 15'h10, 0, 4'hF, 0);
        step();
        check("after_p1_run", last_g, 0);
        set_p0(0, '0, 0, '0, '0); set_p1(0, '0, 0, '0, '0); step();

        // Byte-lane write
        set_p0(1, 15'h40, 1, 4'hF,    32'h11223344); step();
        set_p0(1, 15'h40, 1, 4'b0010, 32'h0000AB00); step();
        set_p0(1, 15'h40, 0, 4'hF,    32'h0);        step();
        check("byte_merge", p0_rdata_o, 32'h1122AB44);

        // Bypass write echoes data and leaves memory untouched
        bypass_en_i = 1'b1;
        set_p0(1, 15'h40, 1, 4'hF, 32'hCAFEF00D); step();
        check("bypass_echo", p0_rdata_o, 32'hCAFEF00D);
        bypass_en_i = 1'b0;
        set_p0(1, 15'h40, 0, 4'hF, 32'h0); step();
        check("bypass_old", p0_rdata_o, 32'h1122AB44);
        set_p0(0, '0, 0, '0, '0); step();

`ifdef SP_RAM_ARB_STALL_CNT_EN
        do_reset();
        set_p0(1, 15'h10, 0, 4'hF, 0);
        set_p1(1, 15'h20, 0, 4'hF, 0);
        repeat (10) step();
        check("stall10_c0", stall_cnt0_o, 32'd5);
        check("stall10_c1", stall_cnt1_o, 32'd5);
        clr_stats_i = 1'b1; step(); clr_stats_i = 1'b0;
        check("clr_c0", stall_cnt0_o, 32'd0);
        check("clr_c1", stall_cnt1_o, 32'd0);
        set_p0(0, '0, 0, '0, '0); set_p1(0, '0, 0, '0, '0); step();
`endif

        // Reset arriving with a granted read drops its response
        set_p0(1, 15'h40, 0, 4'hF, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_drop_rvalid", p0_rvalid_o, 1'b0);
        set_p0(0, '0, 0, '0, '0); step();

        // Randomized traffic; a stalled master holds its request fields
        for (int n = 0; n < 600; n++) begin
            if (!(p0_req_i && last_g != 0))
                set_p0(($urandom % 4) != 0, AW'(($urandom % 16) * 4), $urandom % 2,
                       4'($urandom), $urandom);
            if (!(p1_req_i && last_g != 1))
                set_p1(($urandom % 4) != 0, AW'(($urandom % 16) * 4), $urandom % 2,
                       4'($urandom), $urandom);
            bypass_en_i = ($urandom % 10) == 0;
            clr_stats_i = ($urandom % 20) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
